// File: rtl/debounce_bank.sv
// debounce_bank: bank of independent switch debouncers sharing one sample-tick divider.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer in front of each channel.
module debounce_bank #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 1000000,
    parameter int STABLE_TICKS = 3
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [TW-1:0]   r_tick_cnt;
    logic [TW-1:0]   w_tick_cnt_nxt;
    logic            r_tick;
    logic            w_tick_nxt;
    logic [N_CH-1:0] w_s;
    logic [CW-1:0]   r_cnt [N_CH];
    logic [CW-1:0]   w_cnt_nxt [N_CH];
    logic [N_CH-1:0] r_db;
    logic [N_CH-1:0] w_db_nxt;
    logic [N_CH-1:0] r_rise;
    logic [N_CH-1:0] w_rise_nxt;
    logic [N_CH-1:0] r_fall;
    logic [N_CH-1:0] w_fall_nxt;

`ifdef DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    // Two-stage synchronizer on the raw switch levels
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = sw;
`endif

    // Tick divider next state; the strobe is registered so it lines up with the counter value
    always_comb begin
        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
        if (r_tick_cnt == TICK_LAST) begin
            w_tick_cnt_nxt = '0;
        end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
        end
        w_tick_nxt = (w_tick_cnt_nxt == TICK_LAST);
    end

    // Tick divider state
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    // Per-channel qualification: any agreement restarts, a full run of mismatching ticks flips db
    always_comb begin
        w_db_nxt   = r_db;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_s[i] == r_db[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_tick) begin
                if (r_cnt[i] >= CNT_LAST) begin
                    w_cnt_nxt[i]  = '0;
                    w_db_nxt[i]   = ~r_db[i];
                    w_rise_nxt[i] = ~r_db[i];
                    w_fall_nxt[i] = r_db[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Channel state and edge pulses; pulses share the edge that updates db
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_db   <= w_db_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign db   = r_db;
    assign rise = r_rise;
    assign fall = r_fall;
    assign tick = r_tick;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random switching, checked against a
// run-length model that counts tick instants inside each continuous mismatch interval.
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk_in = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] sw     = '0;
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         tick;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int           c;
    logic [N-1:0] mdb;
    logic [N-1:0] mrise;
    logic [N-1:0] mfall;
    bit           act [N];
    int           start [N];
    logic [N-1:0] h1;
    logic [N-1:0] h2;

    debounce_bank #(.N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .sw     (sw),
        .db     (db),
        .rise   (rise),
        .fall   (fall),
        .tick   (tick)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - a / TD;
    endfunction

    // cycle in which db first shows the flip when s starts differing at cycle a
    function automatic int flip_cycle(input int a);
        int t1;
        t1 = a + (TD - 1 - (a % TD));
        return t1 + (ST - 1) * TD + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    task automatic model_reset();
        c     = 0;
        mdb   = '0;
        mrise = '0;
        mfall = '0;
        h1    = '0;
        h2    = '0;
        for (int i = 0; i < N; i++) begin
            act[i]   = 1'b0;
            start[i] = 0;
        end
    endtask

    task automatic model_cycle(input logic [N-1:0] swv);
        logic [N-1:0] s;
        logic [N-1:0] ndb;
        s     = (LAT == 2) ? h2 : swv;
        ndb   = mdb;
        mrise = '0;
        mfall = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] != mdb[i]) begin
                if (!act[i]) begin
                    act[i]   = 1'b1;
                    start[i] = c;
                end
                if ((c % TD) == TD - 1 && ticks_in(start[i], c) >= ST) begin
                    ndb[i]   = ~mdb[i];
                    mrise[i] = ndb[i];
                    mfall[i] = ~ndb[i];
                    act[i]   = 1'b0;
                end
            end else begin
                act[i] = 1'b0;
            end
        end
        mdb = ndb;
        h2  = h1;
        h1  = swv;
        c++;
    endtask

    task automatic step(input logic [N-1:0] swv);
        chk("tick", {31'd0, tick}, {31'd0, ((c % TD) == TD - 1)});
        chk("db", {28'd0, db}, {28'd0, mdb});
        chk("rise", {28'd0, rise}, {28'd0, mrise});
        chk("fall", {28'd0, fall}, {28'd0, mfall});
        chk("rise_and_fall", {28'd0, rise & fall}, 32'd0);
        sw = swv;
        model_cycle(swv);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {21'd0, db, rise, fall, tick}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("reset_held");
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int  c0;
        int  ef;
        bit  found;
        logic [N-1:0] prev;
        logic [N-1:0] rv;

        model_reset();
        @(negedge clk_in);
        check_reset_outputs("reset_initial");
        @(negedge clk_in);
        reset = 1'b0;

        // quiet inputs: nothing moves, tick every 4th cycle
        for (int k = 0; k < 40; k++) step(4'b0000);

        // single channel rise with explicit latency
        c0 = c;
        ef = flip_cycle(c0 + LAT);
        for (int k = 0; k < 24; k++) begin
            if (c == ef - 1) chk("db0_before_flip", {31'd0, db[0]}, 32'd0);
            if (c == ef) begin
                chk("db0_after_flip", {31'd0, db[0]}, 32'd1);
                chk("rise0_pulse", {31'd0, rise[0]}, 32'd1);
            end
            if (c == ef + 1) chk("rise0_one_cycle", {31'd0, rise[0]}, 32'd0);
            step(4'b0001);
        end
        chk("others_quiet", {29'd0, db[3:1]}, 32'd0);

        // glitch on channel 1 restarts qualification
        for (int k = 0; k < 8; k++) step(4'b0011);
        step(4'b0001);
        for (int k = 0; k < 20; k++) step(4'b0011);

        // channel 2 set then released -> fall pulse
        for (int k = 0; k < 20; k++) step(4'b0111);
        for (int k = 0; k < 20; k++) step(4'b0011);

        // all channels toggled together
        prev = db;
        for (int k = 0; k < 24; k++) begin
            step(4'b1100);
            if (db != prev) begin
                chk("all_flip_same_cycle", {28'd0, db}, {28'd0, prev ^ 4'hF});
                prev = db;
            end
        end
        chk("all_flip_done", {28'd0, db}, 32'hC);

        // reset in the middle of qualification on channel 3
        for (int k = 0; k < 20; k++) step(4'b0000);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(4'b1000);
            if (act[3] && ticks_in(start[3], c - 1) == 2) found = 1'b1;
        end
        chk("mid_qual_reached", {31'd0, found}, 32'd1);
        do_reset();
        ef = flip_cycle(0 + LAT);
        for (int k = 0; k < 24; k++) begin
            if (c == ef - 1) chk("db3_held_after_reset", {31'd0, db[3]}, 32'd0);
            if (c == ef) begin
                chk("db3_set_after_full_run", {31'd0, db[3]}, 32'd1);
                chk("rise3_pulse", {31'd0, rise[3]}, 32'd1);
            end
            step(4'b1000);
        end

        // random switching, biased toward holding levels
        rv = sw;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) rv[i] = ~rv[i];
            end
            step(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
